// File: rtl/score_accum_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : score_accum_pkg                                           |
// | Brief  : Shared encodings for the score engine: judgement grades,  |
// |          FSM state codes, BCD limits and the BCD doubling helper.  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package score_accum_pkg;

  // Judgement grades as delivered by the judge logic
  localparam logic [1:0] GRADE_MISS    = 2'd0;
  localparam logic [1:0] GRADE_GOOD    = 2'd1;
  localparam logic [1:0] GRADE_GREAT   = 2'd2;
  localparam logic [1:0] GRADE_PERFECT = 2'd3;

  // Serial-add FSM: one state per BCD digit
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_ADD0 = 3'd1;
  localparam logic [STATE_W-1:0] S_ADD1 = 3'd2;
  localparam logic [STATE_W-1:0] S_ADD2 = 3'd3;
  localparam logic [STATE_W-1:0] S_ADD3 = 3'd4;

  // Largest displayable score and combo ceiling
  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [7:0]  COMBO_MAX = 8'd255;

  // Doubles a single BCD digit (0..9) into a two-digit BCD value (0..18)
  function automatic logic [7:0] bcd_double(input logic [3:0] pts);
    logic [4:0] dbl;
    dbl = {pts, 1'b0};
    if (dbl > 5'd9) begin
      bcd_double = {4'd1, dbl[3:0] - 4'd10};
    end else begin
      bcd_double = {3'd0, dbl};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_accum_bcd_digit_add.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : score_accum_bcd_digit_add                                 |
// | Brief  : Combinational one-digit BCD adder, a + b + cin with       |
// |          decimal correction. Operands are valid BCD digits.        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module score_accum_bcd_digit_add (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] raw;

  // Binary sum (max 19) folded back into one decimal digit plus carry
  always_comb begin
    raw    = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
    cout_o = (raw > 5'd9);
    // For 10..19 the low nibble wraps modulo 16, so subtracting 10 in
    // four bits lands exactly on 0..9.
    sum_o  = cout_o ? (raw[3:0] - 4'd10) : raw[3:0];
  end

endmodule
`default_nettype wire

// File: rtl/score_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : score_accum                                               |
// | Brief  : Finger Dancer score engine. Accepts hit judgements over   |
// |          ready/valid, adds points into a 4-digit packed-BCD score  |
// |          one digit per cycle, tracks combo, saturates at 9999.     |
// |          Optional macro COMBO_BONUS_EN doubles points once the     |
// |          combo reaches COMBO_THRESH.                               |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module score_accum
  import score_accum_pkg::*;
#(
  parameter logic [3:0] PTS_GOOD     = 4'd1,
  parameter logic [3:0] PTS_GREAT    = 4'd2,
  parameter logic [3:0] PTS_PERFECT  = 4'd5,
  parameter logic [7:0] COMBO_THRESH = 8'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        hit_valid,
  input  logic [1:0]  hit_grade,
  output logic        ready,
  output logic        dropped,
  output logic [15:0] num,
  output logic [7:0]  combo,
  output logic        sat
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [15:0]        num_q;
  logic [11:0]        work_q;      // shadow of the low three new digits
  logic [7:0]         addend_q, addend_d;
  logic               carry_q;
  logic [7:0]         combo_q, combo_d;
  logic               sat_q;
  logic               dropped_q;

  logic               accept;
  logic               combo_hot;
  logic               bonus;
  logic [3:0]         pts;
  logic [3:0]         dig_a, dig_b, dig_sum;
  logic               dig_cout;

  assign accept    = hit_valid & ready;
  assign combo_hot = (combo_q >= COMBO_THRESH);

`ifdef COMBO_BONUS_EN
  assign bonus = combo_hot & (hit_grade != GRADE_MISS);
`else
  // Threshold compare stays in the netlist but is masked off in this build.
  assign bonus = 1'b0 & combo_hot;
`endif

  // State register; clear aborts any add in progress
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: every accept (including MISS) walks all four digits
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ADD0;
      S_ADD0:  state_d = S_ADD1;
      S_ADD1:  state_d = S_ADD2;
      S_ADD2:  state_d = S_ADD3;
      S_ADD3:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: judgements are only taken while idle
  always_comb begin
    ready = (state_q == S_IDLE);
  end

  // Points for the presented grade, combo next value and latched addend
  always_comb begin
    pts = 4'd0;
    case (hit_grade)
      GRADE_GOOD:    pts = PTS_GOOD;
      GRADE_GREAT:   pts = PTS_GREAT;
      GRADE_PERFECT: pts = PTS_PERFECT;
      default:       pts = 4'd0;
    endcase
    addend_d = bonus ? bcd_double(pts) : {4'd0, pts};
    if (hit_grade == GRADE_MISS) begin
      combo_d = 8'd0;
    end else if (combo_q == COMBO_MAX) begin
      combo_d = combo_q;
    end else begin
      combo_d = combo_q + 8'd1;
    end
  end

  // Operand mux feeding the single shared digit adder
  always_comb begin
    dig_a = num_q[3:0];
    dig_b = addend_q[3:0];
    case (state_q)
      S_ADD1: begin
        dig_a = num_q[7:4];
        dig_b = addend_q[7:4];
      end
      S_ADD2: begin
        dig_a = num_q[11:8];
        dig_b = 4'd0;
      end
      S_ADD3: begin
        dig_a = num_q[15:12];
        dig_b = 4'd0;
      end
      default: begin
        dig_a = num_q[3:0];
        dig_b = addend_q[3:0];
      end
    endcase
  end

  score_accum_bcd_digit_add u_digit_add (
    .a_i    (dig_a),
    .b_i    (dig_b),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout)
  );

  // Datapath: latch addend/combo on accept, build digits in the shadow,
  // commit all four at once so the display never sees a partial score
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      num_q    <= 16'h0000;
      work_q   <= 12'h000;
      addend_q <= 8'h00;
      carry_q  <= 1'b0;
      combo_q  <= 8'd0;
      sat_q    <= 1'b0;
    end else begin
      if (accept) begin
        addend_q <= addend_d;
        carry_q  <= 1'b0;
        combo_q  <= combo_d;
      end
      case (state_q)
        S_ADD0: begin
          work_q[3:0] <= dig_sum;
          carry_q     <= dig_cout;
        end
        S_ADD1: begin
          work_q[7:4] <= dig_sum;
          carry_q     <= dig_cout;
        end
        S_ADD2: begin
          work_q[11:8] <= dig_sum;
          carry_q      <= dig_cout;
        end
        S_ADD3: begin
          if (dig_cout || sat_q) begin
            num_q <= BCD_MAX;
            sat_q <= 1'b1;
          end else begin
            num_q <= {dig_sum, work_q};
          end
        end
        default: ;
      endcase
    end
  end

  // One-cycle pulse for each judgement presented while busy
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= hit_valid & ~ready;
    end
  end

  assign dropped = dropped_q;
  assign num     = num_q;
  assign combo   = combo_q;
  assign sat     = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_score_accum.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : tb_score_accum                                            |
// | Brief  : Scoreboard bench for score_accum. Stimulus pushes the     |
// |          expected {sat, combo, num} on each accept; a monitor pops |
// |          and compares whenever the engine commits a new score.     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_score_accum;

  localparam logic [3:0] TB_PTS_GOOD    = 4'd1;
  localparam logic [3:0] TB_PTS_GREAT   = 4'd2;
  localparam logic [3:0] TB_PTS_PERFECT = 4'd5;
  localparam logic [7:0] TB_THRESH      = 8'd2;

  localparam logic [1:0] G_MISS    = 2'd0;
  localparam logic [1:0] G_GOOD    = 2'd1;
  localparam logic [1:0] G_GREAT   = 2'd2;
  localparam logic [1:0] G_PERFECT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_grade = 2'd0;
  logic        ready;
  logic        dropped;
  logic [15:0] num;
  logic [7:0]  combo;
  logic        sat;

  int checks   = 0;
  int failures = 0;
  int drop_cnt = 0;

  // Reference model state
  int m_val   = 0;
  int m_combo = 0;
  bit m_sat   = 1'b0;
  logic [24:0] sb_q[$];

  always #5 clk = ~clk;

  score_accum #(
    .PTS_GOOD     (TB_PTS_GOOD),
    .PTS_GREAT    (TB_PTS_GREAT),
    .PTS_PERFECT  (TB_PTS_PERFECT),
    .COMBO_THRESH (TB_THRESH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .hit_valid (hit_valid),
    .hit_grade (hit_grade),
    .ready     (ready),
    .dropped   (dropped),
    .num       (num),
    .combo     (combo),
    .sat       (sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_val   = 0;
    m_combo = 0;
    m_sat   = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_accept(input logic [1:0] g);
    int p;
    case (g)
      G_GOOD:    p = int'(TB_PTS_GOOD);
      G_GREAT:   p = int'(TB_PTS_GREAT);
      G_PERFECT: p = int'(TB_PTS_PERFECT);
      default:   p = 0;
    endcase
`ifdef COMBO_BONUS_EN
    if (g != G_MISS && m_combo >= int'(TB_THRESH)) p = 2 * p;
`endif
    if (g == G_MISS) m_combo = 0;
    else if (m_combo < 255) m_combo = m_combo + 1;
    if (!m_sat) begin
      m_val = m_val + p;
      if (m_val > 9999) begin
        m_val = 9999;
        m_sat = 1'b1;
      end
    end
    sb_q.push_back({m_sat, 8'(m_combo), to_bcd(m_val)});
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Present one judgement for exactly one accepting edge
  task automatic do_hit(input logic [1:0] g, input bit push);
    wait_ready();
    if (push) model_accept(g);
    hit_grade = g;
    hit_valid = 1'b1;
    @(posedge clk); #1;
    hit_valid = 1'b0;
  endtask

  task automatic hit_done(input logic [1:0] g);
    do_hit(g, 1'b1);
    wait_ready();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
  endtask

  // Monitor: checks digit legality every cycle, pops the scoreboard on commit
  initial begin : monitor
    logic prev_ready;
    logic prev_ctl;
    logic [24:0] exp;
    prev_ready = 1'b1;
    prev_ctl   = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("digit_legal", 32'((num[3:0] <= 4'd9) && (num[7:4] <= 4'd9) &&
                                 (num[11:8] <= 4'd9) && (num[15:12] <= 4'd9)), 32'd1);
      end
      if (dropped) drop_cnt++;
      if (ready && !prev_ready && !prev_ctl) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          exp = sb_q.pop_front();
          check("sb_num",   32'(num),   32'(exp[15:0]));
          check("sb_combo", 32'(combo), 32'(exp[23:16]));
          check("sb_sat",   32'(sat),   32'(exp[24]));
        end
      end
      prev_ready = ready;
      prev_ctl   = clear | ~rst_n;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int d0;
    int n_acc;

    // Reset
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_num",     32'(num),     32'h0000);
    check("rst_combo",   32'(combo),   32'd0);
    check("rst_sat",     32'(sat),     32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_ready",   32'(ready),   32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single PERFECT: four busy cycles, 0005 on commit
    do_hit(G_PERFECT, 1'b1);
    n = 0;
    while (!ready && n < 10) begin
      n++;
      check("mid_add_num_held", 32'(num), 32'h0000);
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(n), 32'd4);
    check("perfect_num", 32'(num), 32'h0005);
    check("perfect_combo", 32'(combo), 32'd1);

    // hit_valid held for 10 edges: 2 accepts, 8 drops
    wait_ready();
    @(negedge clk);
    d0 = drop_cnt;
    @(posedge clk); #1;
    n_acc = 0;
    hit_grade = G_GOOD;
    hit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (ready) begin
        model_accept(G_GOOD);
        n_acc++;
      end
      @(posedge clk); #1;
    end
    hit_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("hold_accepts", 32'(n_acc), 32'd2);
    check("hold_drops", 32'(drop_cnt - d0), 32'd8);
    check("hold_combo", 32'(combo), 32'd3);

    // MISS resets combo, score untouched
    hit_done(G_MISS);
    check("miss_combo", 32'(combo), 32'd0);
`ifdef COMBO_BONUS_EN
    check("miss_num", 32'(num), 32'h0008);
`else
    check("miss_num", 32'(num), 32'h0007);
`endif

    // clear during ADD1, with a judgement on the clear edge
    do_hit(G_PERFECT, 1'b0);
    @(posedge clk); #1;
    clear = 1'b1;
    hit_valid = 1'b1;
    hit_grade = G_GREAT;
    @(posedge clk); #1;
    clear = 1'b0;
    hit_valid = 1'b0;
    model_reset();
    check("clr_num",     32'(num),     32'h0000);
    check("clr_combo",   32'(combo),   32'd0);
    check("clr_ready",   32'(ready),   32'd1);
    check("clr_dropped", 32'(dropped), 32'd0);
    repeat (6) begin @(posedge clk); #1; end
    check("clr_no_commit", 32'(num), 32'h0000);

    // GOOD, GOOD, PERFECT from zero
    hit_done(G_GOOD);
    check("seq_good1", 32'(num), 32'h0001);
    hit_done(G_GOOD);
    check("seq_good2", 32'(num), 32'h0002);
    hit_done(G_PERFECT);
`ifdef COMBO_BONUS_EN
    check("seq_perfect", 32'(num), 32'h0012);
`else
    check("seq_perfect", 32'(num), 32'h0007);
`endif

    // Climb to 0998 with combo kept below the bonus threshold
    do_clear();
    for (int i = 0; i < 199; i++) begin
      do_hit(G_PERFECT, 1'b1);
      do_hit(G_MISS, 1'b1);
    end
    do_hit(G_GOOD, 1'b1);
    do_hit(G_MISS, 1'b1);
    do_hit(G_GOOD, 1'b1);
    do_hit(G_MISS, 1'b1);
    hit_done(G_GOOD);
    check("climb_0998", 32'(num), 32'h0998);
    hit_done(G_GREAT);
    check("ripple_1000", 32'(num), 32'h1000);

    // Climb to 9997, then saturate
    do_hit(G_MISS, 1'b1);
    for (int i = 0; i < 1799; i++) begin
      do_hit(G_PERFECT, 1'b1);
      do_hit(G_MISS, 1'b1);
    end
    hit_done(G_GREAT);
    check("climb_9997", 32'(num), 32'h9997);
    check("pre_sat", 32'(sat), 32'd0);
    hit_done(G_PERFECT);
    check("sat_num", 32'(num), 32'h9999);
    check("sat_flag", 32'(sat), 32'd1);
    hit_done(G_GOOD);
    check("sat_hold_num", 32'(num), 32'h9999);
    check("sat_combo", 32'(combo), 32'd3);
    check("sat_sticky", 32'(sat), 32'd1);

    repeat (3) begin @(posedge clk); #1; end
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
